fir_host_driver: RTL

Host-side initiator for the `fir` accelerator. It takes one job descriptor at a time, then drives the FIR's AXI-Lite slave: writes `Tape_Num` taps, the data length and `ap_start`. It streams samples into the FIR's AXI-Stream slave, forwards results from the FIR's AXI-Stream master, and polls `ap_ctrl` until `ap_done`, which also returns the FIR to idle. It sits between a user-project data mover and `fir`.

---
 rtl/fir_host_driver_pkg.sv | 21 ++
 rtl/axil_master_if.sv | 98 +++++++++
 rtl/fir_host_driver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_host_driver_pkg.sv
// Shared definitions for the fir host driver: FSM states and the fir
// register map as seen over AXI-Lite.
package fir_host_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_TAP,
    ST_WR_LEN,
    ST_WR_START,
    ST_STREAM,
    ST_POLL,
    ST_DONE
  } state_e;

  localparam logic [31:0] AP_CTRL  = 32'h0000_0000;
  localparam logic [31:0] DATA_LEN = 32'h0000_0010;
  localparam logic [31:0] TAP_BASE = 32'h0000_0020;

  localparam int unsigned AP_DONE_BIT = 1;

endpackage

// File: rtl/axil_master_if.sv
// Single-outstanding AXI-Lite master: one write or one read per request,
// acknowledged by a one-cycle pulse after the bus side has completed.
module axil_master_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_req_i,
  input  logic [pADDR_WIDTH-1:0] wr_addr_i,
  input  logic [pDATA_WIDTH-1:0] wr_data_i,
  output logic                   wr_ack_o,
  input  logic                   rd_req_i,
  input  logic [pADDR_WIDTH-1:0] rd_addr_i,
  output logic                   rd_ack_o,
  output logic [pDATA_WIDTH-1:0] rd_data_o,
  output logic                   awvalid_o,
  output logic [pADDR_WIDTH-1:0] awaddr_o,
  input  logic                   awready_i,
  output logic                   wvalid_o,
  output logic [pDATA_WIDTH-1:0] wdata_o,
  input  logic                   wready_i,
  output logic                   arvalid_o,
  output logic [pADDR_WIDTH-1:0] araddr_o,
  input  logic                   arready_i,
  input  logic                   rvalid_i,
  input  logic [pDATA_WIDTH-1:0] rdata_i,
  output logic                   rready_o
);

  logic                   wr_busy_q, wr_ack_q, awvalid_q, wvalid_q;
  logic                   rd_busy_q, rd_ack_q, arvalid_q;
  logic [pADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [pDATA_WIDTH-1:0] wdata_q, rd_data_q;

  // Busy stays set through the ack cycle so a still-held request cannot re-issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_busy_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      rd_busy_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ack_q <= 1'b0;
      if (!wr_busy_q) begin
        if (wr_req_i) begin
          wr_busy_q <= 1'b1;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= wr_addr_i;
          wdata_q   <= wr_data_i;
        end
      end else if (wr_ack_q) begin
        wr_busy_q <= 1'b0;
      end else begin
        if (awready_i) awvalid_q <= 1'b0;
        if (wready_i)  wvalid_q  <= 1'b0;
        if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) wr_ack_q <= 1'b1;
      end

      rd_ack_q <= 1'b0;
      if (!rd_busy_q) begin
        if (rd_req_i) begin
          rd_busy_q <= 1'b1;
          arvalid_q <= 1'b1;
          araddr_q  <= rd_addr_i;
        end
      end else if (rd_ack_q) begin
        rd_busy_q <= 1'b0;
      end else begin
        if (arready_i || rvalid_i) arvalid_q <= 1'b0;
        if (rvalid_i) begin
          rd_ack_q  <= 1'b1;
          rd_data_q <= rdata_i;
        end
      end
    end
  end

  assign wr_ack_o  = wr_ack_q;
  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;
  assign awvalid_o = awvalid_q;
  assign awaddr_o  = awaddr_q;
  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign arvalid_o = arvalid_q;
  assign araddr_o  = araddr_q;
  assign rready_o  = 1'b1;

endmodule

// File: rtl/fir_host_driver.sv
// Host-side initiator for the fir accelerator: programs taps and length,
// starts it, streams samples through and polls ap_ctrl until ap_done.
module fir_host_driver
  import fir_host_driver_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [31:0]            job_len,
  input  logic                   coef_valid,
  output logic                   coef_ready,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [pDATA_WIDTH-1:0] src_data,
  output logic                   dst_valid,
  input  logic                   dst_ready,
  output logic [pDATA_WIDTH-1:0] dst_data,
  output logic                   dst_last,
  output logic                   job_done,
  output logic                   job_err,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready
);

  localparam int unsigned TW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(Tape_Num - 1);
  localparam logic [pDATA_WIDTH-1:0] DONE_MASK = pDATA_WIDTH'(1) << AP_DONE_BIT;

  state_e          state_q, state_d;
  logic [31:0]     len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [TW-1:0]   tap_idx_q, tap_idx_d;
  logic            tap_pend_q, tap_pend_d, err_q, err_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic                   wr_req, wr_ack, rd_req, rd_ack;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data, rd_data;
  logic                   in_act, in_fire, out_fire, last_exp;

  axil_master_if #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_axil (
    .clk_i    (axis_clk),
    .rst_i    (axis_rst),
    .wr_req_i (wr_req),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .wr_ack_o (wr_ack),
    .rd_req_i (rd_req),
    .rd_addr_i(pADDR_WIDTH'(AP_CTRL)),
    .rd_ack_o (rd_ack),
    .rd_data_o(rd_data),
    .awvalid_o(awvalid),
    .awaddr_o (awaddr),
    .awready_i(awready),
    .wvalid_o (wvalid),
    .wdata_o  (wdata),
    .wready_i (wready),
    .arvalid_o(arvalid),
    .araddr_o (araddr),
    .arready_i(arready),
    .rvalid_i (rvalid),
    .rdata_i  (rdata),
    .rready_o (rready)
  );

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      tap_idx_q  <= '0;
      tap_pend_q <= 1'b0;
      gap_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      tap_idx_q  <= tap_idx_d;
      tap_pend_q <= tap_pend_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    tap_idx_d  = tap_idx_q;
    tap_pend_d = tap_pend_q;
    gap_d      = gap_q;
    err_d      = err_q;
    job_ready  = 1'b0;
    coef_ready = 1'b0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_req     = 1'b0;
    ss_tvalid  = 1'b0;
    ss_tdata   = '0;
    ss_tlast   = 1'b0;
    src_ready  = 1'b0;
    dst_valid  = 1'b0;
    dst_data   = '0;
    dst_last   = 1'b0;
    sm_tready  = 1'b0;
    job_done   = 1'b0;
    job_err    = 1'b0;
    in_act     = 1'b0;
    in_fire    = 1'b0;
    out_fire   = 1'b0;
    last_exp   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          len_d      = job_len;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          tap_idx_d  = '0;
          tap_pend_d = 1'b0;
          if (job_len == 32'd0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_WR_TAP;
          end
        end
      end
      ST_WR_TAP: begin
        wr_addr = pADDR_WIDTH'(TAP_BASE) + (pADDR_WIDTH'(tap_idx_q) << 2);
        wr_data = coef_data;
        // The coefficient is consumed in the request cycle; the engine latches it.
        if (!tap_pend_q) begin
          coef_ready = coef_valid;
          wr_req     = coef_valid;
          tap_pend_d = coef_valid;
        end else if (wr_ack) begin
          tap_pend_d = 1'b0;
          if (tap_idx_q == TAP_LAST) state_d = ST_WR_LEN;
          else tap_idx_d = tap_idx_q + 1'b1;
        end
      end
      ST_WR_LEN: begin
        wr_req  = 1'b1;
        wr_addr = pADDR_WIDTH'(DATA_LEN);
        wr_data = pDATA_WIDTH'(len_q);
        if (wr_ack) state_d = ST_WR_START;
      end
      ST_WR_START: begin
        wr_req  = 1'b1;
        wr_addr = pADDR_WIDTH'(AP_CTRL);
        wr_data = pDATA_WIDTH'(1);
        if (wr_ack) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        in_act    = in_cnt_q < len_q;
        ss_tvalid = src_valid && in_act;
        src_ready = ss_tready && in_act;
        ss_tdata  = src_data;
        ss_tlast  = in_cnt_q == len_q - 32'd1;
        in_fire   = src_valid && ss_tready && in_act;
        if (in_fire) in_cnt_d = in_cnt_q + 32'd1;

        last_exp  = out_cnt_q == len_q - 32'd1;
        dst_valid = sm_tvalid;
        dst_data  = sm_tdata;
        dst_last  = last_exp;
        sm_tready = dst_ready;
        out_fire  = sm_tvalid && dst_ready;
        if (out_fire) begin
          out_cnt_d = out_cnt_q + 32'd1;
          if (sm_tlast != last_exp) err_d = 1'b1;
          if (last_exp) begin
            state_d = ST_POLL;
            gap_d   = '0;
          end
        end
      end
      ST_POLL: begin
        rd_req = gap_q == '0;
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        if (rd_ack) begin
          if ((rd_data & DONE_MASK) != '0) state_d = ST_DONE;
          else gap_d = GW'(POLL_GAP);
        end
      end
      ST_DONE: begin
        job_done = 1'b1;
        job_err  = err_q;
        err_d    = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
